// File: rtl/switch_scan_ctrl_if.sv
// Event handshake between the switch scan controller and the CPU input port.
interface switch_scan_ctrl_if #(
   parameter int N = 4
);
   localparam int CW = (N > 1) ? $clog2(N) : 1;

   logic          evValid;
   logic [CW-1:0] evChan;
   logic          evLevel;
   logic          evReady;

   modport master (output evValid, output evChan, output evLevel, input evReady);
   modport slave  (input evValid, input evChan, input evLevel, output evReady);
endinterface

// File: rtl/switch_scan_ctrl.sv
// Round-robin debouncer: N synchronised switches share one debounce counter; commits are reported as events.
// Build option DEBOUNCE_PRESS_ONLY_EN: falling commits update state silently, only rising commits raise events.
module switch_scan_ctrl #(
   parameter int N    = 4,
   parameter int SIZE = 4
) (
   input  logic         clk,
   input  logic         Reset,
   input  logic [N-1:0] in,
   output logic [N-1:0] state,
   switch_scan_ctrl_if.master ev
);
   localparam int CW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {SCAN, CHECK, REPORT} st_e;

   st_e             st_q, st_d;
   logic [N-1:0]    s1_q, syn_q;
   logic [N-1:0]    state_q, state_d;
   logic [CW-1:0]   ptr_q, ptr_d, ptr_nxt;
   logic [SIZE-1:0] cnt_q, cnt_d;
   logic            vld_q, vld_d;
   logic [CW-1:0]   chan_q, chan_d;
   logic            lvl_q, lvl_d;
   logic            mism;

   always_ff @(posedge clk or posedge Reset) begin
      if (Reset) begin
         s1_q  <= '0;
         syn_q <= '0;
      end else begin
         s1_q  <= in;
         syn_q <= s1_q;
      end
   end

   assign ptr_nxt = (ptr_q == CW'(N-1)) ? '0 : ptr_q + 1'b1;
   assign mism    = syn_q[ptr_q] != state_q[ptr_q];

   always_ff @(posedge clk or posedge Reset) begin
      if (Reset) begin
         st_q    <= SCAN;
         state_q <= '0;
         ptr_q   <= '0;
         cnt_q   <= '0;
         vld_q   <= 1'b0;
         chan_q  <= '0;
         lvl_q   <= 1'b0;
      end else begin
         st_q    <= st_d;
         state_q <= state_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
         vld_q   <= vld_d;
         chan_q  <= chan_d;
         lvl_q   <= lvl_d;
      end
   end

   always_comb begin
      st_d    = st_q;
      state_d = state_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      vld_d   = vld_q;
      chan_d  = chan_q;
      lvl_d   = lvl_q;
      case (st_q)
         SCAN: begin
            if (mism) begin
               cnt_d = '0;
               st_d  = CHECK;
            end else begin
               ptr_d = ptr_nxt;
            end
         end
         CHECK: begin
            if (!mism) begin
               // bounced back before the counter saturated: drop it
               cnt_d = '0;
               ptr_d = ptr_nxt;
               st_d  = SCAN;
            end else if (cnt_q != '1) begin
               cnt_d = cnt_q + 1'b1;
            end else begin
               state_d[ptr_q] = ~state_q[ptr_q];
               cnt_d          = '0;
`ifdef DEBOUNCE_PRESS_ONLY_EN
               if (state_q[ptr_q]) begin
                  ptr_d = ptr_nxt;
                  st_d  = SCAN;
               end else
`endif
               begin
                  vld_d  = 1'b1;
                  chan_d = ptr_q;
                  lvl_d  = ~state_q[ptr_q];
                  st_d   = REPORT;
               end
            end
         end
         REPORT: begin
            if (vld_q && ev.evReady) begin
               vld_d = 1'b0;
               ptr_d = ptr_nxt;
               st_d  = SCAN;
            end
         end
         default: st_d = SCAN;
      endcase
   end

   assign state      = state_q;
   assign ev.evValid = vld_q;
   assign ev.evChan  = chan_q;
   assign ev.evLevel = lvl_q;
endmodule
